quadrilatero_lsu_issue_dispatcher: RTL and testbench
====================================================

# quadrilatero_lsu_issue_dispatcher

Multi-unit successor to the single-unit register LSU controller: buffers dispatched load/store instructions in a parametrised in-order queue and issues each one to the next idle load/store unit, with round-robin fairness across `N_UNITS` units. It sits between the quadrilatero dispatcher and the register loader/storer instances. It adds a configurable early-full margin, a flush, a sticky overflow flag, and an optional CSR configuration snapshot at dispatch time.

## Interface
- `N_SLOTS`, 4: queue depth in entries, must be ≥ 2.
- `N_UNITS`, 2: number of downstream LSUs, must be ≥ 1.
- `INSTR_W`, 32: instruction word width.
- `CONF_W`, 32: CSR configuration width.
- `FULL_MARGIN`, 1: `full_o` asserts when `count ≥ N_SLOTS-FULL_MARGIN`; must be in 0..N_SLOTS-1.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, asynchronous and active-high.
- `flush_i` in 1: discard all queued entries.
- `dispatch_i` in 1: push request.
- `dispatched_instr_i` in INSTR_W: instruction to push.
- `csr_config_i` in CONF_W: current matrix configuration.
- `issue_queue_full_o` out 1: early-full indication to the dispatcher.
- `overflow_o` out 1: sticky; set by a push attempted while `count==N_SLOTS`.
- `busy_i` in N_UNITS: per-unit busy.
- `start_o` out N_UNITS: per-unit one-cycle start pulse.
- `issued_instr_o` out N_UNITS*INSTR_W: per-unit issued instruction; unit u occupies bits [u*INSTR_W +: INSTR_W].
- `issued_instr_conf_o` out N_UNITS*CONF_W: per-unit issued configuration, packed the same way.

## Operation
- Queue
  - Circular buffer with read and write pointers wrapping at N_SLOTS (non-power-of-2 depths are legal).
  - Occupancy `count` is $clog2(N_SLOTS+1) bits wide.
  - There is no fall-through: a pushed entry is visible at the head from the cycle after the push.
- Push
  - Accepted iff `dispatch_i && count<N_SLOTS`. A pop in the same cycle does not free space for that push.
  - A rejected push drops the data and sets `overflow_o`. `overflow_o` clears only on reset.
- Eligibility: unit u is eligible when `!busy_i[u] && !start_o[u]`. The `start_o` term covers the one-cycle lag before the unit raises `busy_i`.
- Issue
  - At most one issue per cycle.
  - If the queue is not empty and an eligible unit exists, pop the head and select the first eligible unit at or after `rr_ptr`, wrapping modulo N_UNITS.
- Registered outputs on issue
  - `issued_instr_o[u]` ← head instruction.
  - `issued_instr_conf_o[u]` ← configuration (source is set by the Configuration macro).
  - `start_o[u]` ← 1 for exactly one cycle.
  - `rr_ptr` ← (u+1) mod N_UNITS.
- Non-selected units keep their issued instruction/configuration registers unchanged.
- Simultaneous push and pop: both occur; `count` is unchanged.
- Flush
  - `flush_i` zeroes the pointers and `count` on the next edge, and suppresses any pop in that cycle.
  - A push in the same cycle is discarded.
  - `start_o` pulses already registered still complete.
  - `rr_ptr` and `overflow_o` are unaffected by flush.

## Timing
- Reset values, applied asynchronously: `start_o`=0, `issued_instr_o`=0, `issued_instr_conf_o`=0, `overflow_o`=0, `count`=0, `rr_ptr`=0, and therefore `issue_queue_full_o`=(0 ≥ N_SLOTS-FULL_MARGIN)=0.
- Reset mid-operation discards all queued entries and any pending start.
- Latency with an idle unit: push at edge t, head visible during cycle t, `start_o` high during cycle t+1. Dispatch to start is 2 cycles.
- `issue_queue_full_o` is combinational from `count`; it updates in the cycle after the push or pop that changes `count`.
- Issue throughput is 1 instruction per cycle when enough units are idle. A single unit receives at most one start per 2 cycles.

## Configuration
- `QUADRILATERO_LSU_CONF_SNAPSHOT_EN` defined
  - Each queue entry stores `{csr_config_i, dispatched_instr_i}` as sampled at the push.
  - The issued configuration is the value stored with that entry.
- `QUADRILATERO_LSU_CONF_SNAPSHOT_EN` undefined
  - Queue stores only the instruction.
  - The issued configuration is `csr_config_i` sampled at the issue edge (legacy behaviour).
  - Saves N_SLOTS*CONF_W flops.

## Test plan
- Single push: N_UNITS=2, both idle, push instr 0x11 at edge 0 → `start_o`=2'b01 during cycle 1 only, `issued_instr_o[0]`=0x11; unit 1 outputs remain 0.
- Round-robin: push 0xA1, 0xA2, 0xA3 on consecutive edges, all units always idle → starts go to unit0, unit1, unit0 with those instructions in order, in cycles 1, 2, 3.
- Fill and overflow: N_SLOTS=4, FULL_MARGIN=1, all units busy.
  - Push 3 → `issue_queue_full_o`=1.
  - 4th push accepted, 5th push → `overflow_o`=1; queue holds only the first 4, popped in order once `busy_i` drops.
- Simultaneous push/pop at count=4: push accepted only if a slot is free before the pop → with count=4, the push is rejected, `overflow_o` is set, and `count` becomes 3.
- Config snapshot with macro defined: push with `csr_config_i`=0x5, change it to 0x9 before issue → `issued_instr_conf_o`=0x5. With the macro undefined → 0x9.
- Flush and reset: 3 entries queued, assert `flush_i` for one cycle → no further `start_o`, `count`=0. Assert `rst_i` mid-issue → all outputs read 0 immediately.

Source files
------------

// File: rtl/quadrilatero_lsu_issue_dispatcher.sv
// Purpose : in-order issue queue feeding N_UNITS load/store units, round-robin unit pick.
// Latency : dispatch edge t -> start_o pulse during cycle t+1 (2 cycles) with an idle unit.
// Backpres: issue_queue_full_o raises early (FULL_MARGIN); pushes at true full are dropped and flagged.
//
// Ports:
//   clk_i, rst_i (async, active-high)        clock and reset
//   flush_i                                  drop every queued entry
//   dispatch_i, dispatched_instr_i           push request and instruction
//   csr_config_i                             current matrix configuration
//   issue_queue_full_o                       early-full toward the dispatcher
//   overflow_o                               sticky: push attempted while completely full
//   busy_i[u]                                unit u is executing
//   start_o[u]                               one-cycle start pulse for unit u
//   issued_instr_o[u*INSTR_W +: INSTR_W]     instruction handed to unit u
//   issued_instr_conf_o[u*CONF_W +: CONF_W]  configuration handed to unit u
//
// Build option: QUADRILATERO_LSU_CONF_SNAPSHOT_EN
//   defined   -> each entry captures csr_config_i at push; issued config comes from the entry.
//   undefined -> only the instruction is queued; csr_config_i is sampled at the issue edge.

module quadrilatero_lsu_issue_dispatcher #(
  parameter int N_SLOTS     = 4,
  parameter int N_UNITS     = 2,
  parameter int INSTR_W     = 32,
  parameter int CONF_W      = 32,
  parameter int FULL_MARGIN = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       dispatch_i,
  input  logic [INSTR_W-1:0]         dispatched_instr_i,
  input  logic [CONF_W-1:0]          csr_config_i,
  output logic                       issue_queue_full_o,
  output logic                       overflow_o,
  input  logic [N_UNITS-1:0]         busy_i,
  output logic [N_UNITS-1:0]         start_o,
  output logic [N_UNITS*INSTR_W-1:0] issued_instr_o,
  output logic [N_UNITS*CONF_W-1:0]  issued_instr_conf_o
);

  localparam int CNT_W  = $clog2(N_SLOTS + 1);
  localparam int PTR_W  = $clog2(N_SLOTS);
  localparam int UNIT_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
  // One extra bit so rr_ptr + offset cannot wrap before the explicit modulo.
  localparam int SUM_W  = UNIT_W + 1;

`ifdef QUADRILATERO_LSU_CONF_SNAPSHOT_EN
  localparam int ENTRY_W = INSTR_W + CONF_W;
`else
  localparam int ENTRY_W = INSTR_W;
`endif

  localparam logic [CNT_W-1:0]  SLOTS_C   = CNT_W'(N_SLOTS);
  localparam logic [CNT_W-1:0]  FULL_THR  = CNT_W'(N_SLOTS - FULL_MARGIN);
  localparam logic [PTR_W-1:0]  LAST_SLOT = PTR_W'(N_SLOTS - 1);
  localparam logic [UNIT_W-1:0] LAST_UNIT = UNIT_W'(N_UNITS - 1);
  localparam logic [SUM_W-1:0]  UNITS_C   = SUM_W'(N_UNITS);

  // Queue storage and state
  logic [ENTRY_W-1:0] mem [N_SLOTS];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [UNIT_W-1:0]  rr_ptr;

  // Datapath / control
  logic               push;
  logic               pop;
  logic               empty;
  logic [N_UNITS-1:0] eligible;
  logic               sel_vld;
  logic [UNIT_W-1:0]  sel_unit;
  logic [SUM_W-1:0]   cand;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head;
  logic [INSTR_W-1:0] head_instr;
  logic [CONF_W-1:0]  head_conf;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    // Explicit wrap so non-power-of-2 depths work.
    return (p == LAST_SLOT) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (count == '0);

  // A unit that was just started has not raised busy_i yet; start_o covers that gap.
  assign eligible = ~busy_i & ~start_o;

  // Space is judged on the current count only: a same-cycle pop does not make room.
  assign push = dispatch_i && (count < SLOTS_C) && !flush_i;
  assign pop  = !empty && sel_vld && !flush_i;

  assign issue_queue_full_o = (count >= FULL_THR);

  assign head       = mem[rd_ptr];
  assign head_instr = head[INSTR_W-1:0];

`ifdef QUADRILATERO_LSU_CONF_SNAPSHOT_EN
  assign wr_entry  = {csr_config_i, dispatched_instr_i};
  assign head_conf = head[INSTR_W +: CONF_W];
`else
  assign wr_entry  = dispatched_instr_i;
  assign head_conf = csr_config_i;
`endif

  // First eligible unit at or after rr_ptr, wrapping modulo N_UNITS.
  always_comb begin
    sel_vld  = 1'b0;
    sel_unit = '0;
    cand     = '0;
    for (int k = 0; k < N_UNITS; k++) begin
      cand = SUM_W'(rr_ptr) + SUM_W'(k);
      if (cand >= UNITS_C) begin
        cand = cand - UNITS_C;
      end
      if (!sel_vld && eligible[cand[UNIT_W-1:0]]) begin
        sel_vld  = 1'b1;
        sel_unit = cand[UNIT_W-1:0];
      end
    end
  end

  // Entry storage needs no reset: count gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr              <= '0;
      wr_ptr              <= '0;
      count               <= '0;
      rr_ptr              <= '0;
      overflow_o          <= 1'b0;
      start_o             <= '0;
      issued_instr_o      <= '0;
      issued_instr_conf_o <= '0;
    end else begin
      start_o <= '0;

      if (dispatch_i && (count == SLOTS_C)) begin
        overflow_o <= 1'b1;
      end

      if (flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= ptr_inc(wr_ptr);
        end
        if (pop) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        if (push && !pop) begin
          count <= count + CNT_W'(1);
        end else if (pop && !push) begin
          count <= count - CNT_W'(1);
        end
      end

      // pop already excludes flush, so a flush cycle never issues.
      if (pop) begin
        start_o[sel_unit]                                        <= 1'b1;
        issued_instr_o[int'(sel_unit) * INSTR_W +: INSTR_W]      <= head_instr;
        issued_instr_conf_o[int'(sel_unit) * CONF_W +: CONF_W]   <= head_conf;
        rr_ptr <= (sel_unit == LAST_UNIT) ? '0 : sel_unit + UNIT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_quadrilatero_lsu_issue_dispatcher.sv
// Purpose : self-checking bench for quadrilatero_lsu_issue_dispatcher (default parameters).
// Latency : expects start_o two cycles after the dispatch cycle with an idle unit.
// Backpres: exercises early-full, overflow at true full, flush and mid-issue reset.

module tb_quadrilatero_lsu_issue_dispatcher;

  localparam int N_SLOTS     = 4;
  localparam int N_UNITS     = 2;
  localparam int INSTR_W     = 32;
  localparam int CONF_W      = 32;
  localparam int FULL_MARGIN = 1;
  localparam logic [31:0] C0 = 32'h0000_0077;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       flush;
  logic                       dispatch;
  logic [INSTR_W-1:0]         instr;
  logic [CONF_W-1:0]          csr;
  logic                       full;
  logic                       ovf;
  logic [N_UNITS-1:0]         busy;
  logic [N_UNITS-1:0]         start;
  logic [N_UNITS*INSTR_W-1:0] iinstr;
  logic [N_UNITS*CONF_W-1:0]  iconf;

  quadrilatero_lsu_issue_dispatcher #(
    .N_SLOTS    (N_SLOTS),
    .N_UNITS    (N_UNITS),
    .INSTR_W    (INSTR_W),
    .CONF_W     (CONF_W),
    .FULL_MARGIN(FULL_MARGIN)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .flush_i            (flush),
    .dispatch_i         (dispatch),
    .dispatched_instr_i (instr),
    .csr_config_i       (csr),
    .issue_queue_full_o (full),
    .overflow_o         (ovf),
    .busy_i             (busy),
    .start_o            (start),
    .issued_instr_o     (iinstr),
    .issued_instr_conf_o(iconf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int          unit;
    logic [31:0] instr;
    logic [31:0] conf;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) next_cycle();
  endtask

  task automatic expect_issue(input int unit, input logic [31:0] i, input logic [31:0] c,
                              input int at);
    exp_t e;
    e.unit  = unit;
    e.instr = i;
    e.conf  = c;
    e.at    = at;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    check_val("sb_drained", 64'(sb.size()), 64'(0));
    sb.delete();
    rst      = 1'b1;
    flush    = 1'b0;
    dispatch = 1'b0;
    instr    = '0;
    busy     = '0;
    csr      = C0;
    cycles(2);
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every start pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && start != '0) begin
      if (sb.size() == 0) begin
        check_val("unexpected_start", 64'(start), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        check_val("start_unit", 64'(start), 64'(1) << mon_e.unit);
        check_val("issued_instr", 64'(iinstr[mon_e.unit*INSTR_W +: INSTR_W]), 64'(mon_e.instr));
        check_val("issued_conf", 64'(iconf[mon_e.unit*CONF_W +: CONF_W]), 64'(mon_e.conf));
        check_val("start_cycle", 64'(cyc), 64'(mon_e.at));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    rst      = 1'b1;
    flush    = 1'b0;
    dispatch = 1'b0;
    instr    = '0;
    csr      = C0;
    busy     = '0;
    cycles(2);
    check_val("rst_start", 64'(start), 64'(0));
    check_val("rst_instr", iinstr, 64'(0));
    check_val("rst_conf", iconf, 64'(0));
    check_val("rst_ovf", 64'(ovf), 64'(0));
    check_val("rst_full", 64'(full), 64'(0));
    rst = 1'b0;
    next_cycle();

    // Single push, both units idle
    dispatch = 1'b1;
    instr    = 32'h11;
    expect_issue(0, 32'h11, C0, cyc + 2);
    next_cycle();
    dispatch = 1'b0;
    cycles(4);
    check_val("unit1_instr_idle", 64'(iinstr[63:32]), 64'(0));
    check_val("unit1_conf_idle", 64'(iconf[63:32]), 64'(0));

    // Round-robin on back-to-back pushes
    do_reset();
    for (int i = 0; i < 3; i++) begin
      dispatch = 1'b1;
      instr    = 32'hA1 + 32'(i);
      expect_issue(i % 2, 32'hA1 + 32'(i), C0, cyc + 2);
      next_cycle();
    end
    dispatch = 1'b0;
    cycles(5);

    // Fill with all units busy: early full, overflow on the 5th push
    do_reset();
    busy = 2'b11;
    for (int i = 0; i < 5; i++) begin
      dispatch = 1'b1;
      instr    = 32'hB0 + 32'(i);
      next_cycle();
      check_val("full_after_push", 64'(full), 64'((i + 1) >= 3));
      check_val("ovf_after_push", 64'(ovf), 64'(i == 4));
    end
    dispatch = 1'b0;
    cycles(2);
    d    = cyc;
    busy = 2'b00;
    for (int i = 0; i < 4; i++) begin
      expect_issue(i % 2, 32'hB0 + 32'(i), C0, d + 1 + i);
    end
    cycles(6);
    check_val("ovf_sticky", 64'(ovf), 64'(1));
    check_val("full_drained", 64'(full), 64'(0));

    // Push and pop in the same cycle at count==N_SLOTS: push rejected
    do_reset();
    busy = 2'b11;
    for (int i = 0; i < 4; i++) begin
      dispatch = 1'b1;
      instr    = 32'hC0 + 32'(i);
      next_cycle();
    end
    check_val("ovf_before_collision", 64'(ovf), 64'(0));
    busy  = 2'b10;
    instr = 32'h99;
    expect_issue(0, 32'hC0, C0, cyc + 1);
    next_cycle();
    busy     = 2'b11;
    dispatch = 1'b0;
    check_val("ovf_collision", 64'(ovf), 64'(1));
    check_val("full_collision", 64'(full), 64'(1));
    cycles(2);
    d    = cyc;
    busy = 2'b00;
    expect_issue(1, 32'hC1, C0, d + 1);
    expect_issue(0, 32'hC2, C0, d + 2);
    expect_issue(1, 32'hC3, C0, d + 3);
    cycles(6);
    check_val("full_after_collision_drain", 64'(full), 64'(0));

    // Configuration source: captured at push or sampled at issue
    do_reset();
    busy     = 2'b11;
    csr      = 32'h5;
    dispatch = 1'b1;
    instr    = 32'hD1;
    next_cycle();
    dispatch = 1'b0;
    csr      = 32'h9;
    next_cycle();
    busy = 2'b00;
`ifdef QUADRILATERO_LSU_CONF_SNAPSHOT_EN
    expect_issue(0, 32'hD1, 32'h5, cyc + 1);
`else
    expect_issue(0, 32'hD1, 32'h9, cyc + 1);
`endif
    cycles(4);
    csr = C0;

    // Flush with 3 queued entries; same-cycle push and pop are both suppressed
    do_reset();
    busy = 2'b11;
    for (int i = 0; i < 3; i++) begin
      dispatch = 1'b1;
      instr    = 32'hE0 + 32'(i);
      next_cycle();
    end
    check_val("full_before_flush", 64'(full), 64'(1));
    flush = 1'b1;
    instr = 32'hEE;
    busy  = 2'b00;
    next_cycle();
    flush    = 1'b0;
    dispatch = 1'b0;
    check_val("full_after_flush", 64'(full), 64'(0));
    cycles(5);
    check_val("ovf_after_flush", 64'(ovf), 64'(0));
    dispatch = 1'b1;
    instr    = 32'hEF;
    expect_issue(0, 32'hEF, C0, cyc + 2);
    next_cycle();
    dispatch = 1'b0;
    cycles(4);

    // Reset in the middle of issuing
    do_reset();
    dispatch = 1'b1;
    instr    = 32'hF1;
    expect_issue(0, 32'hF1, C0, cyc + 2);
    next_cycle();
    instr = 32'hF2;
    next_cycle();
    dispatch = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_val("midrst_start", 64'(start), 64'(0));
    check_val("midrst_instr", iinstr, 64'(0));
    check_val("midrst_conf", iconf, 64'(0));
    check_val("midrst_full", 64'(full), 64'(0));
    cycles(2);
    rst = 1'b0;
    cycles(3);
    dispatch = 1'b1;
    instr    = 32'hF3;
    expect_issue(0, 32'hF3, C0, cyc + 2);
    next_cycle();
    dispatch = 1'b0;
    cycles(4);

    check_val("sb_final_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
